// File: rtl/soc_boot_sequencer.sv
// soc_boot_sequencer
//
// Board-level boot and clock-enable controller for the PULPino FPGA top.
// After power-up or a board reset it holds the SoC in reset for a minimum
// time, releases it, waits a short boot delay and then enables instruction
// fetch once the fetch button is pressed. It also produces a divided
// clock-enable pulse for the SoC domain, which replaces the old ripple-derived
// core clock. The reset and fetch push-buttons are synchronized and debounced,
// and a free-running heartbeat drives an LED.
//
// Ports
//   clk            in   1  system clock, all logic on posedge
//   rst            in   1  synchronous, active-high reset
//   ext_rst_n_i    in   1  board reset button, active-low, asynchronous to clk
//   fetch_btn_n_i  in   1  fetch button, active-low, asynchronous to clk
//   soc_ce_o       out  1  single-cycle clock-enable pulse every CLK_DIV cycles
//   soc_rst_n_o    out  1  SoC reset, active-low (high outside HOLD)
//   fetch_enable_o out  1  SoC fetch enable (high only in RUN)
//   heartbeat_o    out  1  LED output, 50% duty, toggles every HB_HALF cycles
//   state_o        out  2  FSM state: 0 HOLD, 1 BOOT, 2 IDLE, 3 RUN

module soc_boot_sequencer #(
    parameter int CLK_DIV      = 10,
    parameter int RST_HOLD_CYC = 16,
    parameter int BOOT_DLY     = 8,
    parameter int DEB_CYC      = 4,
    parameter int HB_HALF      = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_rst_n_i,
    input  logic       fetch_btn_n_i,
    output logic       soc_ce_o,
    output logic       soc_rst_n_o,
    output logic       fetch_enable_o,
    output logic       heartbeat_o,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_BOOT = 2'd1;
    localparam logic [1:0] ST_IDLE = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Counter widths are kept at least one bit so that degenerate parameter
    // values (e.g. DEB_CYC=1) still elaborate cleanly.
    localparam int CE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
    localparam int TMR_MAX = (RST_HOLD_CYC > BOOT_DLY) ? RST_HOLD_CYC : BOOT_DLY;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CE_W-1:0]  CE_LAST   = CE_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HB_HALF - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] BOOT_LAST = TMR_W'(BOOT_DLY - 1);

    logic             ext_s1, ext_s2, ext_db;
    logic             fetch_s1, fetch_s2, fetch_db;
    logic [DEB_W-1:0] ext_cnt, fetch_cnt;
    logic [CE_W-1:0]  ce_cnt;
    logic [HB_W-1:0]  hb_cnt;
    logic [TMR_W-1:0] tmr;
    logic [1:0]       state;

    // Two-flop synchronizers for both buttons. They reset to 1 so that an
    // unpressed (high) button is never seen as a press coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_s1   <= 1'b1;
            ext_s2   <= 1'b1;
            fetch_s1 <= 1'b1;
            fetch_s2 <= 1'b1;
        end else begin
            ext_s1   <= ext_rst_n_i;
            ext_s2   <= ext_s1;
            fetch_s1 <= fetch_btn_n_i;
            fetch_s2 <= fetch_s1;
        end
    end

    // Reset-button debouncer: a new level is accepted only after it has
    // differed from the debounced value for DEB_CYC consecutive cycles; any
    // return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_db  <= 1'b1;
            ext_cnt <= '0;
        end else if (ext_s2 == ext_db) begin
            ext_cnt <= '0;
        end else if (ext_cnt == DEB_LAST) begin
            ext_db  <= ext_s2;
            ext_cnt <= '0;
        end else begin
            ext_cnt <= ext_cnt + 1'b1;
        end
    end

    // Fetch-button debouncer, same scheme as the reset button.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_db  <= 1'b1;
            fetch_cnt <= '0;
        end else if (fetch_s2 == fetch_db) begin
            fetch_cnt <= '0;
        end else if (fetch_cnt == DEB_LAST) begin
            fetch_db  <= fetch_s2;
            fetch_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
        end
    end

    // Clock-enable divider. It free-runs regardless of the FSM so the SoC
    // domain sees a steady enable cadence; the pulse is registered so it is
    // glitch-free and lands one cycle after the counter's last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_cnt   <= '0;
            soc_ce_o <= 1'b0;
        end else begin
            soc_ce_o <= (ce_cnt == CE_LAST);
            if (ce_cnt == CE_LAST) begin
                ce_cnt <= '0;
            end else begin
                ce_cnt <= ce_cnt + 1'b1;
            end
        end
    end

    // Heartbeat LED: toggles each time the half-period counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt      <= '0;
            heartbeat_o <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt      <= '0;
            heartbeat_o <= ~heartbeat_o;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    // Boot FSM. In HOLD the timer saturates, so a long board-reset press
    // still leaves the minimum hold satisfied and release is seen promptly.
    // Outside HOLD a debounced board-reset press wins over every other
    // transition, including a fetch press arriving on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HOLD;
            tmr   <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        if (ext_db) begin
                            state <= ST_BOOT;
                            tmr   <= '0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_BOOT: begin
                    if (!ext_db) begin
                        state <= ST_HOLD;
                        tmr   <= '0;
                    end else if (tmr == BOOT_LAST) begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!ext_db) begin
                        state <= ST_HOLD;
                        tmr   <= '0;
                    end else if (!fetch_db) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (!ext_db) begin
                        state <= ST_HOLD;
                        tmr   <= '0;
                    end
                end
            endcase
        end
    end

    // Outputs are pure decodes of the state register.
    assign state_o        = state;
    assign soc_rst_n_o    = (state != ST_HOLD);
    assign fetch_enable_o = (state == ST_RUN);

endmodule

// File: tb/tb_soc_boot_sequencer.sv
// tb_soc_boot_sequencer
//
// Directed testbench for soc_boot_sequencer using the reduced parameter set
// CLK_DIV=5, RST_HOLD_CYC=8, BOOT_DLY=4, DEB_CYC=3, HB_HALF=6. Inputs change
// and outputs are sampled 1 time unit after each rising edge; "edge k" means
// the k-th rising edge after an input change.

module tb_soc_boot_sequencer;

    logic       clk;
    logic       rst;
    logic       ext_rst_n_i;
    logic       fetch_btn_n_i;
    logic       soc_ce_o;
    logic       soc_rst_n_o;
    logic       fetch_enable_o;
    logic       heartbeat_o;
    logic [1:0] state_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    soc_boot_sequencer #(
        .CLK_DIV      (5),
        .RST_HOLD_CYC (8),
        .BOOT_DLY     (4),
        .DEB_CYC      (3),
        .HB_HALF      (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_rst_n_i    (ext_rst_n_i),
        .fetch_btn_n_i  (fetch_btn_n_i),
        .soc_ce_o       (soc_ce_o),
        .soc_rst_n_o    (soc_rst_n_o),
        .fetch_enable_o (fetch_enable_o),
        .heartbeat_o    (heartbeat_o),
        .state_o        (state_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for three edges with buttons released; every output must
    // be at its reset value.
    task automatic test_reset();
        rst           = 1'b1;
        ext_rst_n_i   = 1'b1;
        fetch_btn_n_i = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (soc_ce_o !== 1'b0) $display("[TB] FAIL reset_ce: got %b expected 0", soc_ce_o);
        else pass_cnt++;
        total_cnt++;
        if (soc_rst_n_o !== 1'b0) $display("[TB] FAIL reset_soc_rst_n: got %b expected 0", soc_rst_n_o);
        else pass_cnt++;
        total_cnt++;
        if (fetch_enable_o !== 1'b0) $display("[TB] FAIL reset_fetch_en: got %b expected 0", fetch_enable_o);
        else pass_cnt++;
        total_cnt++;
        if (heartbeat_o !== 1'b0) $display("[TB] FAIL reset_heartbeat: got %b expected 0", heartbeat_o);
        else pass_cnt++;
        total_cnt++;
        if (state_o !== 2'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state_o);
        else pass_cnt++;
    endtask

    // Power-up: HOLD for 8 edges, BOOT for 4, then IDLE. CE pulses on every
    // 5th edge and the heartbeat toggles on edges 6 and 12.
    task automatic test_power_up();
        logic [1:0] exp_state;
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_state = (k < 8) ? 2'd0 : ((k < 12) ? 2'd1 : 2'd2);
            total_cnt++;
            if (state_o !== exp_state) $display("[TB] FAIL pwr_state edge %0d: got %0d expected %0d", k, state_o, exp_state);
            else pass_cnt++;
            total_cnt++;
            if (soc_rst_n_o !== (k >= 8)) $display("[TB] FAIL pwr_soc_rst_n edge %0d: got %b expected %b", k, soc_rst_n_o, (k >= 8));
            else pass_cnt++;
            total_cnt++;
            if (soc_ce_o !== (k % 5 == 0)) $display("[TB] FAIL pwr_ce edge %0d: got %b expected %b", k, soc_ce_o, (k % 5 == 0));
            else pass_cnt++;
            total_cnt++;
            if (heartbeat_o !== ((k / 6) % 2 == 1)) $display("[TB] FAIL pwr_heartbeat edge %0d: got %b expected %b", k, heartbeat_o, ((k / 6) % 2 == 1));
            else pass_cnt++;
        end
    endtask

    // A two-cycle fetch glitch in IDLE must never reach the debounced level.
    task automatic test_fetch_glitch();
        fetch_btn_n_i = 1'b0;
        tick();
        tick();
        fetch_btn_n_i = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (state_o !== 2'd2) $display("[TB] FAIL glitch_state edge %0d: got %0d expected 2", k, state_o);
            else pass_cnt++;
            total_cnt++;
            if (fetch_enable_o !== 1'b0) $display("[TB] FAIL glitch_fetch_en edge %0d: got %b expected 0", k, fetch_enable_o);
            else pass_cnt++;
        end
    endtask

    // Fetch press in IDLE: RUN appears on edge 6 (2 sync + 3 debounce + 1)
    // and stays after the button is released.
    task automatic test_fetch_press();
        fetch_btn_n_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total_cnt++;
            if (state_o !== ((k < 6) ? 2'd2 : 2'd3)) $display("[TB] FAIL fetch_state edge %0d: got %0d expected %0d", k, state_o, ((k < 6) ? 2'd2 : 2'd3));
            else pass_cnt++;
            total_cnt++;
            if (fetch_enable_o !== (k >= 6)) $display("[TB] FAIL fetch_en edge %0d: got %b expected %b", k, fetch_enable_o, (k >= 6));
            else pass_cnt++;
        end
        fetch_btn_n_i = 1'b1;
        repeat (8) tick();
        total_cnt++;
        if (state_o !== 2'd3) $display("[TB] FAIL fetch_release_state: got %0d expected 3", state_o);
        else pass_cnt++;
        total_cnt++;
        if (fetch_enable_o !== 1'b1) $display("[TB] FAIL fetch_release_en: got %b expected 1", fetch_enable_o);
        else pass_cnt++;
    endtask

    // Board reset held for 20 cycles while in RUN: outputs drop on edge 6,
    // and after release soc_rst_n_o rises on edge 6 with IDLE on edge 10.
    task automatic test_ext_reset();
        ext_rst_n_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total_cnt++;
            if (soc_rst_n_o !== (k < 6)) $display("[TB] FAIL ext_press_soc_rst_n edge %0d: got %b expected %b", k, soc_rst_n_o, (k < 6));
            else pass_cnt++;
            total_cnt++;
            if (fetch_enable_o !== (k < 6)) $display("[TB] FAIL ext_press_fetch_en edge %0d: got %b expected %b", k, fetch_enable_o, (k < 6));
            else pass_cnt++;
        end
        ext_rst_n_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (soc_rst_n_o !== (k >= 6)) $display("[TB] FAIL ext_release_soc_rst_n edge %0d: got %b expected %b", k, soc_rst_n_o, (k >= 6));
            else pass_cnt++;
        end
        total_cnt++;
        if (state_o !== 2'd2) $display("[TB] FAIL ext_release_state: got %0d expected 2", state_o);
        else pass_cnt++;
    endtask

    // Both buttons pressed together in IDLE: board reset wins, so the state
    // goes 2 -> 0 on edge 6 and never visits RUN. After release it reboots.
    task automatic test_both_buttons();
        ext_rst_n_i   = 1'b0;
        fetch_btn_n_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (state_o !== ((k < 6) ? 2'd2 : 2'd0)) $display("[TB] FAIL both_state edge %0d: got %0d expected %0d", k, state_o, ((k < 6) ? 2'd2 : 2'd0));
            else pass_cnt++;
        end
        ext_rst_n_i   = 1'b1;
        fetch_btn_n_i = 1'b1;
        repeat (6) tick();
        total_cnt++;
        if (state_o !== 2'd1) $display("[TB] FAIL both_reboot_state: got %0d expected 1", state_o);
        else pass_cnt++;
        repeat (4) tick();
        total_cnt++;
        if (state_o !== 2'd2) $display("[TB] FAIL both_idle_state: got %0d expected 2", state_o);
        else pass_cnt++;
    endtask

    // rst asserted while in RUN returns the FSM to HOLD on the next edge.
    task automatic test_rst_from_run();
        fetch_btn_n_i = 1'b0;
        repeat (6) tick();
        fetch_btn_n_i = 1'b1;
        total_cnt++;
        if (state_o !== 2'd3) $display("[TB] FAIL run_entry_state: got %0d expected 3", state_o);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (state_o !== 2'd0) $display("[TB] FAIL run_rst_state: got %0d expected 0", state_o);
        else pass_cnt++;
        total_cnt++;
        if (fetch_enable_o !== 1'b0) $display("[TB] FAIL run_rst_fetch_en: got %b expected 0", fetch_enable_o);
        else pass_cnt++;
        total_cnt++;
        if (soc_rst_n_o !== 1'b0) $display("[TB] FAIL run_rst_soc_rst_n: got %b expected 0", soc_rst_n_o);
        else pass_cnt++;
    endtask

    // Heartbeat from a fresh release toggles on edge 6; rst at edge 9
    // clears it on the following edge.
    task automatic test_heartbeat_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total_cnt++;
            if (heartbeat_o !== (k >= 6)) $display("[TB] FAIL hb_edge %0d: got %b expected %b", k, heartbeat_o, (k >= 6));
            else pass_cnt++;
        end
        rst = 1'b1;
        tick();
        total_cnt++;
        if (heartbeat_o !== 1'b0) $display("[TB] FAIL hb_rst_heartbeat: got %b expected 0", heartbeat_o);
        else pass_cnt++;
        total_cnt++;
        if (state_o !== 2'd0) $display("[TB] FAIL hb_rst_state: got %0d expected 0", state_o);
        else pass_cnt++;
        total_cnt++;
        if (soc_ce_o !== 1'b0) $display("[TB] FAIL hb_rst_ce: got %b expected 0", soc_ce_o);
        else pass_cnt++;
    endtask

    // Scenario sequence; each task leaves the DUT in the state the next expects.
    initial begin
        rst           = 1'b1;
        ext_rst_n_i   = 1'b1;
        fetch_btn_n_i = 1'b1;
        test_reset();
        test_power_up();
        test_fetch_glitch();
        test_fetch_press();
        test_ext_reset();
        test_both_buttons();
        test_rst_from_run();
        test_heartbeat_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
